pdp8_bus_responder: RTL and testbench

- Target end of the CPU's 8-bit multiplexed nibble bus. Decodes address, IO-intro and data beats and returns 4-bit read nibbles on `bus_in`.
- Contains a 12-bit-wide synchronous-write word memory.
- Bridges IO cycles to a simple device port.
- Sits at the top level between the CPU bus pins and the memory/peripheral models. It is used in simulation and as a self-contained SoC target.

---
 rtl/pdp8_bus_pkg.sv | 57 +++++
 rtl/pdp8_word_ram.sv | 24 ++
 rtl/pdp8_bus_responder.sv | 185 ++++++++++++++++++
 tb/tb_pdp8_bus_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_bus_pkg.sv
// Shared definitions for the PDP-8 nibble-bus responder: beat types, beat
// prefixes, word geometry and the beat decoder.
package pdp8_bus_pkg;

  localparam int WORD_W   = 12;
  localparam int NIB_W    = 4;
  localparam int NIB0_LSB = 0;
  localparam int NIB1_LSB = 4;
  localparam int NIB2_LSB = 8;

  // Prefixes on bus_out[7:5]; address beats only look at [7:6].
  localparam logic [2:0] PFX_ADDR_LO = 3'b100;
  localparam logic [2:0] PFX_ADDR_HI = 3'b110;
  localparam logic [2:0] PFX_IO      = 3'b011;
  localparam logic [2:0] PFX_D0      = 3'b000;
  localparam logic [2:0] PFX_D1      = 3'b001;
  localparam logic [2:0] PFX_D2      = 3'b010;

  typedef enum logic [2:0] {
    ADDR_LO,
    ADDR_HI,
    IO,
    D0,
    D1,
    D2,
    BAD
  } beat_t;

  typedef enum logic [2:0] {
    IDLE,
    GOT_LO,
    GOT_HI,
    GOT_IO,
    GOT_D0,
    GOT_D1
  } state_t;

  function automatic beat_t decode_beat(input logic [7:0] b);
    beat_t t;
    t = BAD;
    if (b[7:6] == PFX_ADDR_LO[2:1]) begin
      t = ADDR_LO;
    end else if (b[7:6] == PFX_ADDR_HI[2:1]) begin
      t = ADDR_HI;
    end else begin
      case (b[7:5])
        PFX_IO:  t = IO;
        PFX_D0:  t = D0;
        PFX_D1:  t = D1;
        PFX_D2:  t = D2;
        default: t = BAD;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/pdp8_word_ram.sv
// 12-bit word memory: combinational read, synchronous write. Not reset.
module pdp8_word_ram
  import pdp8_bus_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**AW];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pdp8_bus_responder.sv
// Target end of the PDP-8 multiplexed nibble bus. Decodes address, IO and
// data beats, owns the word memory and bridges IO cycles to a device port.
// Optional build macro: PDP8_ROM_PROTECT_EN (write-protect addr >= ROM_BASE,
// adds the sticky wp_err output).
//
// state  | meaning
// IDLE   | waiting for ADDR_LO
// GOT_LO | low address bits latched, expecting ADDR_HI
// GOT_HI | full address latched and memory word read, expecting IO or D0
// GOT_IO | IO cycle, device/function latched, expecting D0
// GOT_D0 | first data nibble seen, expecting D1
// GOT_D1 | second data nibble seen, expecting D2 (commit)
module pdp8_bus_responder
  import pdp8_bus_pkg::*;
#(
  parameter int          AW       = 12,
  parameter logic [11:0] ROM_BASE = 12'hF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  bus_out,
  output logic [3:0]  bus_in,
  input  logic        irq_in,
  output logic [5:0]  io_dev,
  output logic [2:0]  io_func,
  output logic [11:0] io_wdata,
  output logic        io_wr,
  output logic        io_rd_ack,
  input  logic [11:0] io_rdata,
  input  logic        io_ready,
  input  logic        io_skip,
`ifdef PDP8_ROM_PROTECT_EN
  output logic        wp_err,
`endif
  output logic        proto_err
);

`ifdef PDP8_ROM_PROTECT_EN
  localparam bit ROM_PROTECT = 1'b1;
`else
  localparam bit ROM_PROTECT = 1'b0;
`endif

  state_t state, state_nxt;
  beat_t  beat;

  logic [5:0]        addr_lo, addr_hi;
  logic [WORD_W-1:0] rword;
  logic [7:0]        wbuf;
  logic              w_q;
  logic              is_io;

  logic beat_err;
  logic lat_lo, lat_hi, lat_io, take_d0, take_d1, take_d2;
  logic w_mismatch, commit_wr, mem_we, io_commit, rom_hit, rom_drop;

  logic [11:0]       raddr_full, waddr_full;
  logic [WORD_W-1:0] commit_word, ram_rdata;

  assign beat        = decode_beat(bus_out);
  assign raddr_full  = {bus_out[5:0], addr_lo};
  assign waddr_full  = {addr_hi, addr_lo};
  assign commit_word = {bus_out[3:0], wbuf};
  assign rom_hit     = (waddr_full >= ROM_BASE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: any illegal beat falls back to IDLE, except ADDR_LO restarts.
  always_comb begin
    state_nxt = IDLE;
    beat_err  = 1'b0;
    if (beat == ADDR_LO) begin
      state_nxt = GOT_LO;
      beat_err  = (state != IDLE);
    end else begin
      case (state)
        GOT_LO: if (beat == ADDR_HI) state_nxt = GOT_HI; else beat_err = 1'b1;
        GOT_HI: begin
          if (beat == IO)      state_nxt = GOT_IO;
          else if (beat == D0) state_nxt = GOT_D0;
          else                 beat_err  = 1'b1;
        end
        GOT_IO: if (beat == D0) state_nxt = GOT_D0; else beat_err = 1'b1;
        GOT_D0: if (beat == D1) state_nxt = GOT_D1; else beat_err = 1'b1;
        GOT_D1: if (beat == D2) state_nxt = IDLE;   else beat_err = 1'b1;
        default: beat_err = 1'b1;
      endcase
    end
  end

  // Per-beat strobes and the returned nibble (no path from memory to bus_in).
  always_comb begin
    lat_lo     = (beat == ADDR_LO);
    lat_hi     = (state == GOT_LO) && (beat == ADDR_HI);
    lat_io     = (state == GOT_HI) && (beat == IO);
    take_d0    = ((state == GOT_HI) || (state == GOT_IO)) && (beat == D0);
    take_d1    = (state == GOT_D0) && (beat == D1);
    take_d2    = (state == GOT_D1) && (beat == D2);
    w_mismatch = (take_d1 || take_d2) && (bus_out[4] != w_q);
    commit_wr  = take_d2 && w_q;
    rom_drop   = ROM_PROTECT && rom_hit;
    mem_we     = commit_wr && !is_io && !rom_drop && !reset;
    io_commit  = commit_wr && is_io;
    bus_in     = 4'h0;
    if (!reset) begin
      case (beat)
        IO:      bus_in = {1'b0, irq_in, io_skip, io_ready};
        D0:      bus_in = rword[NIB2_LSB +: NIB_W];
        D1:      bus_in = rword[NIB1_LSB +: NIB_W];
        D2:      bus_in = rword[NIB0_LSB +: NIB_W];
        default: bus_in = 4'h0;
      endcase
    end
  end

  // Cycle datapath: address, read word, write buffer and IO port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_lo   <= '0;
      addr_hi   <= '0;
      rword     <= '0;
      wbuf      <= '0;
      w_q       <= 1'b0;
      is_io     <= 1'b0;
      io_dev    <= '0;
      io_func   <= '0;
      io_wdata  <= '0;
      io_wr     <= 1'b0;
      io_rd_ack <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      io_wr     <= 1'b0;
      io_rd_ack <= 1'b0;
      if (lat_lo) begin
        addr_lo <= bus_out[5:0];
        is_io   <= 1'b0;
      end
      if (lat_hi) begin
        addr_hi <= bus_out[5:0];
        rword   <= ram_rdata;
      end
      if (lat_io) begin
        io_dev  <= addr_lo;
        io_func <= bus_out[2:0];
        is_io   <= 1'b1;
        if (!bus_out[4]) begin
          rword     <= io_rdata;
          io_rd_ack <= 1'b1;
        end
      end
      if (take_d0) begin
        w_q <= bus_out[4];
        if (bus_out[4]) wbuf[3:0] <= bus_out[3:0];
      end
      if (take_d1 && w_q) wbuf[7:4] <= bus_out[3:0];
      if (io_commit) begin
        io_wdata <= commit_word;
        io_wr    <= 1'b1;
      end
      if (beat_err || w_mismatch) proto_err <= 1'b1;
    end
  end

`ifdef PDP8_ROM_PROTECT_EN
  // Sticky flag for memory writes dropped by the protected region.
  always_ff @(posedge clk) begin
    if (reset)                           wp_err <= 1'b0;
    else if (commit_wr && !is_io && rom_hit) wp_err <= 1'b1;
  end
`endif

  pdp8_word_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr_full[AW-1:0]),
    .wdata (commit_word),
    .raddr (raddr_full[AW-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_pdp8_bus_responder.sv
// Bench for pdp8_bus_responder: table-driven beat stream with a nibble
// scoreboard, plus hand sequences for error, reset and write-protect cases.
module tb_pdp8_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  bus_out;
  logic [3:0]  bus_in;
  logic        irq_in;
  logic [5:0]  io_dev;
  logic [2:0]  io_func;
  logic [11:0] io_wdata;
  logic        io_wr;
  logic        io_rd_ack;
  logic [11:0] io_rdata;
  logic        io_ready;
  logic        io_skip;
  logic        proto_err;
`ifdef PDP8_ROM_PROTECT_EN
  logic        wp_err;
`endif

  always #5 clk = ~clk;

  pdp8_bus_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus_out   (bus_out),
    .bus_in    (bus_in),
    .irq_in    (irq_in),
    .io_dev    (io_dev),
    .io_func   (io_func),
    .io_wdata  (io_wdata),
    .io_wr     (io_wr),
    .io_rd_ack (io_rd_ack),
    .io_rdata  (io_rdata),
    .io_ready  (io_ready),
    .io_skip   (io_skip),
`ifdef PDP8_ROM_PROTECT_EN
    .wp_err    (wp_err),
`endif
    .proto_err (proto_err)
  );

  typedef struct {
    logic [7:0]  beat;
    logic        nib_v;
    logic [3:0]  nib;
    logic        wr;
    logic        ack;
    logic        io_v;
    logic [5:0]  dev;
    logic [2:0]  func;
    logic [11:0] wdata;
  } vec_t;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_nib;
  vec_t       vecs[$];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one beat at a falling edge, score bus_in mid-beat, return at the
  // next falling edge so registered outputs reflect this beat's edge.
  task automatic beat(input logic [7:0] b, input logic nv, input logic [3:0] nib);
    logic [3:0] e;
    bus_out = b;
    if (nv) exp_q.push_back(nib);
    #1;
    last_nib = bus_in;
    if (nv) begin
      e = exp_q.pop_front();
      check($sformatf("bus_in beat %02h", b), {8'h0, bus_in}, {8'h0, e});
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [7:0] b, input logic nv, input logic [3:0] n,
                              input logic wr, input logic ack, input logic iov,
                              input logic [5:0] dev, input logic [2:0] fn,
                              input logic [11:0] wd);
    vec_t v;
    v.beat = b; v.nib_v = nv; v.nib = n; v.wr = wr; v.ack = ack;
    v.io_v = iov; v.dev = dev; v.func = fn; v.wdata = wd;
    return v;
  endfunction

  task automatic read_word(input logic [7:0] lo, input logic [7:0] hi, output logic [11:0] w);
    beat(lo, 1'b0, 4'h0);
    beat(hi, 1'b0, 4'h0);
    beat(8'h00, 1'b0, 4'h0); w[11:8] = last_nib;
    beat(8'h20, 1'b0, 4'h0); w[7:4]  = last_nib;
    beat(8'h40, 1'b0, 4'h0); w[3:0]  = last_nib;
  endtask

  task automatic read_chk(input logic [7:0] lo, input logic [7:0] hi, input logic [11:0] w);
    beat(lo, 1'b1, 4'h0);
    beat(hi, 1'b1, 4'h0);
    beat(8'h00, 1'b1, w[11:8]);
    beat(8'h20, 1'b1, w[7:4]);
    beat(8'h40, 1'b1, w[3:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [11:0] old_w;
    reset    = 1'b1;
    bus_out  = 8'h63;
    irq_in   = 1'b1;
    io_ready = 1'b1;
    io_skip  = 1'b0;
    io_rdata = 12'h3E7;
    repeat (3) @(negedge clk);
    #1;
    check("reset bus_in", {8'h0, bus_in}, 12'h0);
    check("reset io_dev", {6'h0, io_dev}, 12'h0);
    check("reset io_func", {9'h0, io_func}, 12'h0);
    check("reset io_wdata", io_wdata, 12'h0);
    check("reset io_wr", {11'h0, io_wr}, 12'h0);
    check("reset io_rd_ack", {11'h0, io_rd_ack}, 12'h0);
    check("reset proto_err", {11'h0, proto_err}, 12'h0);
`ifdef PDP8_ROM_PROTECT_EN
    check("reset wp_err", {11'h0, wp_err}, 12'h0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // write A5C to 123, read it back, IO read dev 5, IO write dev 2, reread
    vecs.push_back(mk(8'hA3, 0, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'hC4, 0, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h1C, 0, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h35, 0, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h5A, 0, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'hA3, 1, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'hC4, 1, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h00, 1, 4'hA, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h20, 1, 4'h5, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h40, 1, 4'hC, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h85, 1, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'hC0, 1, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h63, 1, 4'h5, 0, 1, 1, 6'd5, 3'd3, 12'h000));
    vecs.push_back(mk(8'h00, 1, 4'h3, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h20, 1, 4'hE, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h40, 1, 4'h7, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h82, 1, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'hC0, 1, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h71, 1, 4'h5, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h14, 0, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h32, 0, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h59, 0, 4'h0, 1, 0, 1, 6'd2, 3'd1, 12'h924));
    vecs.push_back(mk(8'hA3, 1, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'hC4, 1, 4'h0, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h00, 1, 4'hA, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h20, 1, 4'h5, 0, 0, 0, 6'd0, 3'd0, 12'h000));
    vecs.push_back(mk(8'h40, 1, 4'hC, 0, 0, 0, 6'd0, 3'd0, 12'h000));

    for (int i = 0; i < vecs.size(); i++) begin
      beat(vecs[i].beat, vecs[i].nib_v, vecs[i].nib);
      check($sformatf("io_wr v%0d", i), {11'h0, io_wr}, {11'h0, vecs[i].wr});
      check($sformatf("io_rd_ack v%0d", i), {11'h0, io_rd_ack}, {11'h0, vecs[i].ack});
      check($sformatf("proto_err v%0d", i), {11'h0, proto_err}, 12'h0);
      if (vecs[i].io_v) begin
        check($sformatf("io_dev v%0d", i), {6'h0, io_dev}, {6'h0, vecs[i].dev});
        check($sformatf("io_func v%0d", i), {9'h0, io_func}, {9'h0, vecs[i].func});
        check($sformatf("io_wdata v%0d", i), io_wdata, vecs[i].wdata);
      end
    end

    // D0 while idle, then a normal write/read cycle still works
    beat(8'h00, 1'b0, 4'h0);
    check("proto_err after idle D0", {11'h0, proto_err}, 12'h1);
    beat(8'h81, 1'b0, 4'h0);
    beat(8'hC1, 1'b0, 4'h0);
    beat(8'h15, 1'b0, 4'h0);
    beat(8'h3A, 1'b0, 4'h0);
    beat(8'h55, 1'b0, 4'h0);
    read_chk(8'h81, 8'hC1, 12'h5A5);
    read_chk(8'hA3, 8'hC4, 12'hA5C);

    // reset during D1 of a write to 010 must drop the write
    beat(8'h90, 1'b0, 4'h0);
    beat(8'hC0, 1'b0, 4'h0);
    beat(8'h1E, 1'b0, 4'h0);
    beat(8'h3B, 1'b0, 4'h0);
    beat(8'h50, 1'b0, 4'h0);
    beat(8'h90, 1'b0, 4'h0);
    beat(8'hC0, 1'b0, 4'h0);
    beat(8'h1F, 1'b0, 4'h0);
    reset = 1'b1;
    beat(8'h3F, 1'b1, 4'h0);
    reset = 1'b0;
    check("io_wr after reset", {11'h0, io_wr}, 12'h0);
    check("proto_err after reset", {11'h0, proto_err}, 12'h0);
    check("io_dev after reset", {6'h0, io_dev}, 12'h0);
    check("io_wdata after reset", io_wdata, 12'h0);
    read_chk(8'h90, 8'hC0, 12'h0BE);
    check("proto_err idle after reset", {11'h0, proto_err}, 12'h0);

    // w flips on D1: flagged, but the D0 write intent stands
    beat(8'h81, 1'b0, 4'h0);
    beat(8'hC1, 1'b0, 4'h0);
    beat(8'h13, 1'b0, 4'h0);
    beat(8'h27, 1'b0, 4'h0);
    beat(8'h51, 1'b0, 4'h0);
    check("proto_err w mismatch", {11'h0, proto_err}, 12'h1);
    read_chk(8'h81, 8'hC1, 12'h173);

`ifdef PDP8_ROM_PROTECT_EN
    check("wp_err before rom write", {11'h0, wp_err}, 12'h0);
    read_word(8'h85, 8'hFC, old_w);
    beat(8'h85, 1'b0, 4'h0);
    beat(8'hFC, 1'b0, 4'h0);
    beat(8'h17, 1'b0, 4'h0);
    beat(8'h37, 1'b0, 4'h0);
    beat(8'h57, 1'b0, 4'h0);
    check("wp_err after rom write", {11'h0, wp_err}, 12'h1);
    read_chk(8'h85, 8'hFC, old_w);
    beat(8'hBF, 1'b0, 4'h0);
    beat(8'hFB, 1'b0, 4'h0);
    beat(8'h13, 1'b0, 4'h0);
    beat(8'h32, 1'b0, 4'h0);
    beat(8'h51, 1'b0, 4'h0);
    read_chk(8'hBF, 8'hFB, 12'h123);
`else
    old_w = 12'h0;
    read_word(8'h85, 8'hFC, old_w);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
